// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core tile sequencer: FSM state encoding,
// bit positions of the 34-bit core instruction word, and the idle instruction.
package core_ctrl_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_WR    = 4'd1,
    W_L0    = 4'd2,
    W_LOAD  = 4'd3,
    W_DRAIN = 4'd4,
    X_WR    = 4'd5,
    X_L0    = 4'd6,
    EXEC    = 4'd7,
    OFIFO   = 4'd8,
    DONE_ST = 4'd9
  } state_t;

  // Instruction word bit positions.
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_HI    = 30;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_HI    = 17;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both SRAMs deselected (active-low CEN/WEN high), everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1800C0000;

  // Named control fields before packing into the instruction word.
  typedef struct packed {
    logic              acc;
    logic              cen_p;
    logic              wen_p;
    logic [ADDR_W-1:0] a_p;
    logic              cen_x;
    logic              wen_x;
    logic [ADDR_W-1:0] a_x;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    acc:      1'b0,
    cen_p:    1'b1,
    wen_p:    1'b1,
    a_p:      '0,
    cen_x:    1'b1,
    wen_x:    1'b1,
    a_x:      '0,
    ofifo_rd: 1'b0,
    ififo_wr: 1'b0,
    ififo_rd: 1'b0,
    l0_rd:    1'b0,
    l0_wr:    1'b0,
    execute:  1'b0,
    load:     1'b0
  };

endpackage

// File: rtl/core_ctrl_inst_pack.sv
// Combinational packing of the named control fields into the core's 34-bit
// instruction word. Kept separate so the bit layout lives in one place.
module ctrl_inst_pack
  import core_ctrl_pkg::*;
(
  input  ctrl_t             ctrl_i,
  output logic [INST_W-1:0] inst_o
);

  // Place each field at its fixed position in the instruction word.
  always_comb begin
    inst_o                  = '0;
    inst_o[B_ACC]           = ctrl_i.acc;
    inst_o[B_CEN_P]         = ctrl_i.cen_p;
    inst_o[B_WEN_P]         = ctrl_i.wen_p;
    inst_o[B_AP_HI:B_AP_LO] = ctrl_i.a_p;
    inst_o[B_CEN_X]         = ctrl_i.cen_x;
    inst_o[B_WEN_X]         = ctrl_i.wen_x;
    inst_o[B_AX_HI:B_AX_LO] = ctrl_i.a_x;
    inst_o[B_OFIFO_RD]      = ctrl_i.ofifo_rd;
    inst_o[B_IFIFO_WR]      = ctrl_i.ififo_wr;
    inst_o[B_IFIFO_RD]      = ctrl_i.ififo_rd;
    inst_o[B_L0_RD]         = ctrl_i.l0_rd;
    inst_o[B_L0_WR]         = ctrl_i.l0_wr;
    inst_o[B_EXEC]          = ctrl_i.execute;
    inst_o[B_LOAD]          = ctrl_i.load;
  end

endmodule

// File: rtl/core_ctrl.sv
// Tile sequencer in front of the core datapath. Streams one weight tile and
// then len activation vectors from the host into the X/W SRAMs, stages them
// into L0, runs kernel load and execute, then drains the OFIFO into psum SRAM
// at consecutive addresses and pulses done.
//
// Host handshake: a beat transfers on every rising edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state and counter
// (never on in_valid), so the host may hold in_valid high or insert gaps
// freely; in_data must be stable while in_valid is high.
//
// The instruction word, xw_mode, busy and done are registered: the controls
// decided in a cycle appear on the outputs one cycle later. D_xmem is a
// straight pass-through of in_data.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int bw        = 4,
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int ADD_WIDTH = 11,   // must match the 11-bit address fields of inst
  parameter int DRAIN_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADD_WIDTH-1:0] len,
  input  logic [ADD_WIDTH-1:0] w_base,
  input  logic [ADD_WIDTH-1:0] x_base,
  input  logic [ADD_WIDTH-1:0] p_base,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [row*bw-1:0]    in_data,
  input  logic                 ofifo_valid,
  output logic [INST_W-1:0]    inst,
  output logic                 xw_mode,
  output logic [row*bw-1:0]    D_xmem,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  // Counter is one bit wider than an address so it can reach len (X_L0 runs
  // len+1 cycles) and col without overflow.
  localparam int            CW         = ADD_WIDTH + 1;
  localparam logic [CW-1:0] COL_N      = CW'(col);
  localparam logic [CW-1:0] COL_LAST   = CW'(col - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADD_WIDTH-1:0] len_q, w_base_q, x_base_q, p_base_q;
  logic [INST_W-1:0]    inst_q, inst_d;
  logic                 xw_mode_q, xw_mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  ctrl_t                ctrl_d;
  logic [CW-1:0]        len_n, len_last;
  logic                 hs;

  assign len_n    = {1'b0, len_q};
  assign len_last = len_n - CW'(1);
  assign hs       = in_valid & in_ready;

  // Host-side ready: open only in the two SRAM write states while beats remain.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      W_WR:    in_ready = (cnt_q < COL_N);
      X_WR:    in_ready = (cnt_q < len_n);
      default: in_ready = 1'b0;
    endcase
  end

  // State, counter, latched job parameters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      p_base_q  <= '0;
      inst_q    <= INST_IDLE;
      xw_mode_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      xw_mode_q <= xw_mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (state_q == IDLE && start) begin
        len_q    <= len;
        w_base_q <= w_base;
        x_base_q <= x_base;
        p_base_q <= p_base;
      end
    end
  end

  // Next-state and per-state counter; the counter clears on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = W_WR;
      end
      W_WR: begin
        if (hs) begin
          if (cnt_q == COL_LAST) begin
            state_d = W_L0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      W_L0: begin
        if (cnt_q == COL_N) begin
          state_d = W_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      W_LOAD: begin
        if (cnt_q == COL_LAST) begin
          state_d = W_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      W_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = (len_q == '0) ? DONE_ST : X_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      X_WR: begin
        if (hs) begin
          if (cnt_q == len_last) begin
            state_d = X_L0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      X_L0: begin
        if (cnt_q == len_n) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXEC: begin
        if (cnt_q == len_last) begin
          state_d = OFIFO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OFIFO: begin
        if (ofifo_valid) begin
          if (cnt_q == len_last) begin
            state_d = DONE_ST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE_ST: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control fields for this cycle; registered into inst/xw_mode/busy/done.
  // SRAM read data arrives one cycle after the read, so l0_wr trails the
  // xmem reads by one cycle in the L0 staging states.
  always_comb begin
    ctrl_d    = CTRL_IDLE;
    xw_mode_d = 1'b0;
    busy_d    = (state_q != IDLE);
    done_d    = (state_q == DONE_ST);
    unique case (state_q)
      W_WR: begin
        xw_mode_d = 1'b1;
        if (hs) begin
          ctrl_d.cen_x = 1'b0;
          ctrl_d.wen_x = 1'b0;
          ctrl_d.a_x   = w_base_q + cnt_q[ADD_WIDTH-1:0];
        end
      end
      W_L0: begin
        xw_mode_d = 1'b1;
        if (cnt_q < COL_N) begin
          ctrl_d.cen_x = 1'b0;
          ctrl_d.a_x   = w_base_q + cnt_q[ADD_WIDTH-1:0];
        end
        ctrl_d.l0_wr = (cnt_q != '0);
      end
      W_LOAD: begin
        ctrl_d.load  = 1'b1;
        ctrl_d.l0_rd = 1'b1;
      end
      X_WR: begin
        if (hs) begin
          ctrl_d.cen_x = 1'b0;
          ctrl_d.wen_x = 1'b0;
          ctrl_d.a_x   = x_base_q + cnt_q[ADD_WIDTH-1:0];
        end
      end
      X_L0: begin
        if (cnt_q < len_n) begin
          ctrl_d.cen_x = 1'b0;
          ctrl_d.a_x   = x_base_q + cnt_q[ADD_WIDTH-1:0];
        end
        ctrl_d.l0_wr = (cnt_q != '0);
      end
      EXEC: begin
        ctrl_d.execute = 1'b1;
        ctrl_d.l0_rd   = 1'b1;
      end
      OFIFO: begin
        // OFIFO read and psum write happen in the same cycle.
        if (ofifo_valid) begin
          ctrl_d.ofifo_rd = 1'b1;
          ctrl_d.cen_p    = 1'b0;
          ctrl_d.wen_p    = 1'b0;
          ctrl_d.a_p      = p_base_q + cnt_q[ADD_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  ctrl_inst_pack u_pack (
    .ctrl_i (ctrl_d),
    .inst_o (inst_d)
  );

  assign inst      = inst_q;
  assign xw_mode   = xw_mode_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign D_xmem    = in_data;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: expected SRAM/L0/OFIFO instruction events are pushed
// to a queue when a job is launched and popped by a monitor whenever the DUT
// shows a non-idle instruction word.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int DW  = ROW * BW;

  localparam logic [33:0] IDLE_INST = 34'h1800C0000;
  localparam logic [6:0]  LO_NONE    = 7'b0000000;
  localparam logic [6:0]  LO_L0WR    = 7'b0000100;
  localparam logic [6:0]  LO_LOAD_RD = 7'b0001001;
  localparam logic [6:0]  LO_EXEC_RD = 7'b0001010;
  localparam logic [6:0]  LO_OFRD    = 7'b1000000;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] len, w_base, x_base, p_base;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data, D_xmem;
  logic          ofifo_valid;
  logic [33:0]   inst;
  logic          xw_mode, busy, done;
  state_t        dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  logic [34:0] exp_q[$];

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .xw_mode     (xw_mode),
    .D_xmem      (D_xmem),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected {xw_mode, inst} built from the documented field layout.
  function automatic logic [34:0] ev(input logic xw, input logic cp, input logic wp,
                                     input logic [10:0] ap, input logic cx, input logic wx,
                                     input logic [10:0] ax, input logic [6:0] lo);
    return {xw, 1'b0, cp, wp, ap, cx, wx, ax, lo};
  endfunction

  // Scoreboard monitor: every non-idle instruction must match the next expected event.
  always @(negedge clk) begin
    if (reset && inst !== IDLE_INST) begin
      check("sram_exclusive", 64'(!inst[19] && !inst[32]), 64'd0);
      if (exp_q.size() == 0)
        check("unexpected_inst", {29'b0, xw_mode, inst}, {29'b0, 1'b0, IDLE_INST});
      else
        check("inst_stream", {29'b0, xw_mode, inst}, {29'b0, exp_q.pop_front()});
    end
  end

  task automatic push_run(input int l, input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                          input logic [AW-1:0] pb);
    for (int i = 0; i < COL; i++)
      exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, wb + AW'(i), LO_NONE));
    for (int i = 0; i <= COL; i++) begin
      if (i < COL)
        exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, wb + AW'(i),
                           (i == 0) ? LO_NONE : LO_L0WR));
      else
        exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, LO_L0WR));
    end
    for (int i = 0; i < COL; i++)
      exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, LO_LOAD_RD));
    if (l > 0) begin
      for (int i = 0; i < l; i++)
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, xb + AW'(i), LO_NONE));
      for (int i = 0; i <= l; i++) begin
        if (i < l)
          exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, xb + AW'(i),
                             (i == 0) ? LO_NONE : LO_L0WR));
        else
          exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, LO_L0WR));
      end
      for (int i = 0; i < l; i++)
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, LO_EXEC_RD));
      for (int i = 0; i < l; i++)
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, pb + AW'(i), 1'b1, 1'b1, 11'd0, LO_OFRD));
    end
  endtask

  // Driver: one-cycle start pulse, then scramble the job inputs.
  task automatic do_start(input int l, input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                          input logic [AW-1:0] pb);
    @(negedge clk);
    start = 1'b1; len = AW'(l); w_base = wb; x_base = xb; p_base = pb;
    @(negedge clk);
    start = 1'b0;
    len = AW'($urandom); w_base = AW'($urandom); x_base = AW'($urandom); p_base = AW'($urandom);
  endtask

  // Driver: push 'total' host beats, optionally pausing for gap_len cycles
  // once COL+gap_at beats have been accepted.
  task automatic feed(input int total, input int gap_at, input int gap_len);
    int n = 0;
    int guard = 0;
    int gap_left = gap_len;
    int gap_idx = 0;
    while (n < total && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gap_at >= 0 && n == COL + gap_at && gap_left > 0) begin
        in_valid = 1'b0;
        #1;
        check("gap_in_ready", 64'(in_ready), 64'd1);
        if (gap_idx > 0) check("gap_inst_idle", 64'(inst), 64'(IDLE_INST));
        gap_left--;
        gap_idx++;
      end else begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        #1;
        if (in_ready) begin
          check("d_xmem", 64'(D_xmem), 64'(in_data));
          n++;
        end
      end
    end
    if (n < total) check("feed_timeout", 64'(n), 64'(total));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Driver: once in OFIFO, present ofifo_valid from pat (LSB first), then 1s.
  task automatic drain_ofifo(input int l, input logic [15:0] pat, input int plen);
    int guard = 0;
    int acc = 0;
    int k = 0;
    while (dbg_state != OFIFO && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_ofifo", 64'(dbg_state == OFIFO), 64'd1);
    if (dbg_state == OFIFO) begin
      while (acc < l) begin
        ofifo_valid = (k < plen) ? pat[k] : 1'b1;
        if (ofifo_valid) begin
          acc++;
          last_acc_cyc = cyc;
        end
        k++;
        @(negedge clk);
      end
    end
    ofifo_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int exp_done_cyc);
    int g = 0;
    while (!done && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", 64'(done), 64'd1);
    if (done) begin
      if (exp_done_cyc >= 0) check("done_timing", 64'(cyc), 64'(exp_done_cyc));
      check("busy_at_done", 64'(busy), 64'd1);
      check("stream_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
      check("idle_after_done", 64'(dbg_state), 64'(IDLE));
    end
  endtask

  initial begin
    int g;
    int l;
    int ga;
    reset = 1'b0; start = 1'b0; len = '0; w_base = '0; x_base = '0; p_base = '0;
    in_valid = 1'b0; in_data = '0; ofifo_valid = 1'b0;

    // Reset values
    #12;
    check("rst_inst", 64'(inst), 64'(IDLE_INST));
    check("rst_xw_mode", 64'(xw_mode), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Abort in the middle of weight L0 staging
    push_run(2, 11'd0, 11'd10, 11'd20);
    do_start(2, 11'd0, 11'd10, 11'd20);
    feed(COL, -1, 0);
    g = 0;
    while (inst[2] !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("reach_w_l0", 64'(inst[2]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_inst", 64'(inst), 64'(IDLE_INST));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    reset = 1'b1;

    // len=3, x_base wraps, host gap during X_WR, OFIFO valid 1,0,1,1
    push_run(3, 11'd0, 11'd2046, 11'd5);
    do_start(3, 11'd0, 11'd2046, 11'd5);
    feed(COL + 3, 1, 4);
    drain_ofifo(3, 16'b1101, 4);
    wait_done(200, last_acc_cyc + 2);

    // len=0 with weight address wrap; a start while busy must be ignored
    push_run(0, 11'd2044, 11'd0, 11'd0);
    do_start(0, 11'd2044, 11'd300, 11'd400);
    feed(COL, -1, 0);
    repeat (3) @(negedge clk);
    start = 1'b1; len = 11'd5; w_base = 11'd77; x_base = 11'd88; p_base = 11'd99;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, -1);
    repeat (3) begin
      @(negedge clk);
      check("stay_idle_busy", 64'(busy), 64'd0);
      check("stay_idle_inst", 64'(inst), 64'(IDLE_INST));
    end

    // Randomised jobs
    for (int r = 0; r < 3; r++) begin
      logic [AW-1:0] wb, xb, pb;
      l  = $urandom_range(4, 12);
      ga = $urandom_range(1, l - 1);
      wb = AW'($urandom); xb = AW'($urandom); pb = AW'($urandom);
      push_run(l, wb, xb, pb);
      do_start(l, wb, xb, pb);
      feed(COL + l, ga, $urandom_range(1, 3));
      drain_ofifo(l, 16'($urandom), 16);
      wait_done(300, last_acc_cyc + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Tile sequencer directly upstream of the core datapath. Produces the 34-bit `inst` word, the `xw_mode` select and the `D_xmem` write data.
- Streams one weight tile, then `len` activation vectors from a host valid/ready port into the X/W SRAMs.
- Stages both into L0, runs the kernel load and execute phases, then drains the OFIFO into psum SRAM at consecutive addresses.
- Pulses `done` when finished.

Parameters:
- bw, 4, activation/weight element width
- row, 8, PE rows; one SRAM word = row*bw bits
- col, 8, PE columns; one weight tile = col words
- ADD_WIDTH, 11, SRAM address width
- DRAIN_CYC, 16, idle cycles after kernel load before activations enter (row+col)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  ADD_WIDTH  number of activation vectors, 0..2047
- w_base, x_base, p_base  in  ADD_WIDTH each  SRAM base addresses, latched at start
- in_valid  in  1  host data valid
- in_ready  out  1  controller accepts in_data this cycle
- in_data  in  row*bw  host data (col weight words, then len activation words)
- ofifo_valid  in  1  core OFIFO holds a full output vector
- inst  out  34  core instruction word
- xw_mode  out  1  0 = activation SRAM, 1 = weight SRAM
- D_xmem  out  row*bw  SRAM write data (= in_data, combinational)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entry to IDLE from OFIFO

Behaviour:
- inst fields:
  - [33] acc, always 0
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- Idle inst = 34'h1800C0000: both CEN/WEN high, all other bits 0. All SRAM control bits are active-low.
- Reset values: inst = idle, xw_mode = 0, in_ready = 0, busy = 0, done = 0, state = IDLE, all counters = 0. Reset asserted mid-operation aborts immediately and returns to IDLE; no done pulse.
- All outputs except D_xmem are registered. in_ready is the one exception: it is combinational from state AND (cnt < limit).
- FSM (cnt is the per-state counter, cleared on every transition):
  - IDLE: on start, latch len and the three bases, go to W_WR. A start received while busy is ignored.
  - W_WR: xw_mode = 1, in_ready = 1. Each in_valid&&in_ready cycle sets CEN_x = 0, WEN_x = 0, A_x = w_base+cnt, cnt++. After col beats, go to W_L0. A gap in in_valid holds state with inst idle.
  - W_L0: xw_mode = 1. For cnt 0..col-1: CEN_x = 0, WEN_x = 1, A_x = w_base+cnt. SRAM Q has 1-cycle latency, so l0_wr is asserted in cycles 1..col. The state lasts col+1 cycles, then goes to W_LOAD.
  - W_LOAD: load = 1, l0_rd = 1 for col cycles, then go to W_DRAIN.
  - W_DRAIN: inst idle for DRAIN_CYC cycles. Then go to X_WR, or to DONE_ST if len == 0.
  - X_WR: same as W_WR with xw_mode = 0, base x_base, len beats.
  - X_L0: same as W_L0 with xw_mode = 0, x_base, len reads; lasts len+1 cycles.
  - EXEC: execute = 1, l0_rd = 1 for len cycles, then go to OFIFO.
  - OFIFO: each cycle with ofifo_valid asserts ofifo_rd = 1, CEN_p = 0, WEN_p = 0, A_p = p_base+cnt, cnt++ (the psum write is in the same cycle as the OFIFO read). After len writes, go to DONE_ST.
  - DONE_ST: one cycle with done = 1, then go to IDLE.
- Address arithmetic is modulo 2^ADD_WIDTH: base+cnt wraps past 2047 to 0.
- xmem and pmem controls are never active in the same cycle.
- ififo_wr and ififo_rd are always 0.

Decomposition:
- Package core_ctrl_pkg holds:
  - the state enum (IDLE, W_WR, W_L0, W_LOAD, W_DRAIN, X_WR, X_L0, EXEC, OFIFO, DONE_ST)
  - inst bit-position constants
  - INST_IDLE
- One sub-module, ctrl_inst_pack: combinational packing of the named control fields into the 34-bit inst. The result is registered in core_ctrl.

Test Plan:
- Reset mid-W_L0 (assert reset low) -> inst = 34'h1800C0000, busy = 0 in the same cycle; no done; the next start runs a full sequence normally.
- col = 8, w_base = 0, in_valid held high -> 8 writes to A_x 0..7 with xw_mode = 1; W_L0 shows CEN_x low on cycles 0..7 and l0_wr high on cycles 1..8; then 8 cycles of load & l0_rd.
- len = 3, x_base = 2046 -> writes to addresses 2046, 2047, 0; EXEC lasts exactly 3 cycles.
- len = 3, p_base = 5, ofifo_valid toggled 1,0,1,1 -> psum writes to 5, 6, 7 only in valid cycles; done pulses 2 cycles after the last write; busy drops with done's falling edge.
- in_valid deasserted for 4 cycles during X_WR -> inst idle during the gap, in_ready stays 1, no address skipped.
- len = 0 -> weight phases run; DRAIN goes straight to DONE_ST; no xmem write with xw_mode = 0 and no pmem activity; start during busy -> ignored.
